// File: rtl/mmio_io_if.sv
// mmio_io_if: bundles the X/W-stage MMIO access signals and the UART byte
// handshakes between the core (master) and mmio_io_ctrl (slave).
//   addr_x/load_x/store_x/wdata_x : X-stage access (address, kind, store data)
//   stall                         : pipeline hold, suppresses access effects
//   inst_retire                   : one instruction retires in W this cycle
//   uart_rx_data/valid/ready      : receiver byte into the controller
//   uart_tx_data/valid/ready      : transmitter byte out of the controller
//   io_rdata                      : registered read word for the W stage
interface mmio_io_if;
  logic [31:0] addr_x;
  logic        load_x;
  logic        store_x;
  logic [31:0] wdata_x;
  logic        stall;
  logic        inst_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [31:0] io_rdata;

  modport master (
    output addr_x, load_x, store_x, wdata_x, stall, inst_retire,
           uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  uart_rx_ready, uart_tx_data, uart_tx_valid, io_rdata
  );

  modport slave (
    input  addr_x, load_x, store_x, wdata_x, stall, inst_retire,
           uart_rx_data, uart_rx_valid, uart_tx_ready,
    output uart_rx_ready, uart_tx_data, uart_tx_valid, io_rdata
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O controller at 0x8000_00xx.
// Owns the one-byte UART RX and TX buffers, the cycle and retired-instruction
// counters, and the registered read word presented to the W stage.
// Ports:
//   clk  : core clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mmio_io_if.slave (X-stage access, UART handshakes, io_rdata)
// CNT_W sets the counter width (1..32); counters read back zero-extended.
module mmio_io_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mmio_io_if.slave  bus
);

  localparam logic [31:0] ADDR_CTRL = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX   = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX   = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYC  = 32'h8000_0010;
  localparam logic [31:0] ADDR_INST = 32'h8000_0014;
  localparam logic [31:0] ADDR_CRST = 32'h8000_0018;

  typedef enum logic {TX_IDLE, TX_PEND} tx_state_t;

  tx_state_t        tx_state, tx_state_next;
  logic             tx_load, tx_overrun_set;
  logic [7:0]       tx_buf, rx_buf;
  logic             tx_overrun, rx_full;
  logic [CNT_W-1:0] cyc_cnt, inst_cnt;
  logic [31:0]      cyc_ext, inst_ext, rd_word;

  logic qual_load, qual_store, rx_capture, rx_clear, cnt_clear;

  assign qual_load  = bus.load_x  && !bus.stall;
  assign qual_store = bus.store_x && !bus.stall;

  // uart_rx_ready is low while full, so capture and clear are exclusive.
  assign rx_capture = bus.uart_rx_valid && !rx_full;
  assign rx_clear   = qual_load && (bus.addr_x == ADDR_RX) && rx_full;
  assign cnt_clear  = qual_store && (bus.addr_x == ADDR_CRST);

  assign bus.uart_rx_ready = !rx_full;
  assign bus.uart_tx_valid = (tx_state == TX_PEND);
  assign bus.uart_tx_data  = tx_buf;

  // TX state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_next;
  end

  // TX next state. A store while PEND (including the handshake cycle itself)
  // is dropped and flags an overrun.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    tx_state_next  = tx_state;
    tx_load        = 1'b0;
    tx_overrun_set = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (qual_store && (bus.addr_x == ADDR_TX)) begin
          tx_load       = 1'b1;
          tx_state_next = TX_PEND;
        end
      end
      TX_PEND: begin
        if (qual_store && (bus.addr_x == ADDR_TX)) tx_overrun_set = 1'b1;
        if (bus.uart_tx_ready)                     tx_state_next  = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf     <= '0;
      tx_overrun <= 1'b0;
    end else begin
      if (tx_load)        tx_buf     <= bus.wdata_x[7:0];
      if (tx_overrun_set) tx_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf  <= '0;
      rx_full <= 1'b0;
    end else if (rx_capture) begin
      rx_buf  <= bus.uart_rx_data;
      rx_full <= 1'b1;
    end else if (rx_clear) begin
      rx_full <= 1'b0;
    end
  end

  // Counter clear wins over the same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (bus.inst_retire) inst_cnt <= inst_cnt + 1'b1;
    end
  end

  // Read mux over pre-edge state; unmapped and write-only addresses read 0.
  always_comb begin
    cyc_ext              = '0;
    inst_ext             = '0;
    cyc_ext[CNT_W-1:0]   = cyc_cnt;
    inst_ext[CNT_W-1:0]  = inst_cnt;
    rd_word              = '0;
    case (bus.addr_x)
      ADDR_CTRL: rd_word = {29'b0, tx_overrun, rx_full, (tx_state == TX_IDLE)};
      ADDR_RX:   rd_word = {24'b0, rx_buf};
      ADDR_CYC:  rd_word = cyc_ext;
      ADDR_INST: rd_word = inst_ext;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            bus.io_rdata <= '0;
    else if (qual_load) bus.io_rdata <= rd_word;
  end

endmodule
